// File: rtl/sync_shift_ctrl_pkg.sv
// Shared sync-path definitions: controller state encoding and default widths.
// Imported by the capture controller and anything that decodes its state.
package sync_shift_ctrl_pkg;

  localparam int LEN_W_DEF = 7;
  localparam int FRM_W_DEF = 8;
  localparam int TO_W_DEF  = 16;

  // A cfg_len of zero selects a full 64-bit frame.
  localparam int FULL_FRAME = 64;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ARM       = 3'd1;
  localparam logic [2:0] S_WAIT_SYNC = 3'd2;
  localparam logic [2:0] S_SHIFT     = 3'd3;
  localparam logic [2:0] S_GAP       = 3'd4;
  localparam logic [2:0] S_DONE      = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE      = S_IDLE,
    ST_ARM       = S_ARM,
    ST_WAIT_SYNC = S_WAIT_SYNC,
    ST_SHIFT     = S_SHIFT,
    ST_GAP       = S_GAP,
    ST_DONE      = S_DONE
  } state_t;

endpackage

// File: rtl/sync_shift_ctrl_pulse_gen.sv
// Registered one-cycle clear pulse for the sync FSM; the controller raises
// req only on the single transition that needs the clear.
module sync_pulse_gen (
  input  logic clk,
  input  logic rst,
  input  logic req,
  output logic pulse
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pulse <= 1'b0;
    end else begin
      pulse <= req;
    end
  end

endmodule

// File: rtl/sync_shift_ctrl.sv
// Capture-run controller: arms the sync FSM, waits for sync, drives sh_en
// for one frame per sync, and counts frames until the requested run length.
module sync_shift_ctrl
  import sync_shift_ctrl_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF,
  parameter int FRM_W = FRM_W_DEF,
  parameter int TO_W  = TO_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             sync_state,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [FRM_W-1:0] cfg_frames,
  input  logic [TO_W-1:0]  cfg_timeout,
  output logic             sh_en,
  output logic             fsm_rst,
  output logic             busy,
  output logic             frame_done,
  output logic             done,
  output logic [FRM_W-1:0] frame_cnt,
  output logic             timeout_err,
  output logic             sync_err
);

  // The bit counter must reach 63 even when cfg_len is narrower than 7 bits.
  localparam int CNT_W = (LEN_W > 7) ? LEN_W : 7;

  state_t           state_reg, state_next;
  logic [LEN_W-1:0] len_reg, len_next;
  logic [FRM_W-1:0] frames_reg, frames_next;
  logic [TO_W-1:0]  to_reg, to_next;
  logic [TO_W-1:0]  timer_reg, timer_next;
  logic [CNT_W-1:0] bit_reg, bit_next;
  logic [CNT_W-1:0] last_bit;
  logic             gap_reg, gap_next;
  logic [FRM_W-1:0] frame_cnt_reg, frame_cnt_next;
  logic             timeout_err_reg, timeout_err_next;
  logic             sync_err_reg, sync_err_next;
  logic             sh_en_reg, busy_reg, frame_done_reg, done_reg;
  logic             fsm_rst_req;

  assign last_bit = (len_reg == '0) ? CNT_W'(FULL_FRAME - 1)
                                    : CNT_W'(len_reg) - CNT_W'(1);

  always_comb begin
    state_next       = state_reg;
    len_next         = len_reg;
    frames_next      = frames_reg;
    to_next          = to_reg;
    timer_next       = timer_reg;
    bit_next         = bit_reg;
    gap_next         = gap_reg;
    frame_cnt_next   = frame_cnt_reg;
    timeout_err_next = timeout_err_reg;
    sync_err_next    = sync_err_reg;
    fsm_rst_req      = 1'b0;

    unique case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next       = ST_ARM;
          len_next         = cfg_len;
          frames_next      = cfg_frames;
          to_next          = cfg_timeout;
          frame_cnt_next   = '0;
          timeout_err_next = 1'b0;
          sync_err_next    = 1'b0;
          fsm_rst_req      = 1'b1;
        end
      end
      ST_ARM: begin
        timer_next = '0;
        state_next = (frames_reg == '0) ? ST_DONE : ST_WAIT_SYNC;
      end
      ST_WAIT_SYNC: begin
        // Sync arriving on the final permitted cycle still wins.
        if (sync_state) begin
          state_next = ST_SHIFT;
          bit_next   = '0;
        end else if ((to_reg != '0) && (timer_reg + TO_W'(1) == to_reg)) begin
          state_next       = ST_IDLE;
          timeout_err_next = 1'b1;
          fsm_rst_req      = 1'b1;
        end else begin
          timer_next = timer_reg + TO_W'(1);
        end
      end
      ST_SHIFT: begin
        if (!sync_state) begin
          state_next    = ST_IDLE;
          sync_err_next = 1'b1;
          fsm_rst_req   = 1'b1;
        end else if (bit_reg == last_bit) begin
          state_next = ST_GAP;
          gap_next   = 1'b0;
          if (frame_cnt_reg != {FRM_W{1'b1}}) begin
            frame_cnt_next = frame_cnt_reg + FRM_W'(1);
          end
        end else begin
          bit_next = bit_reg + CNT_W'(1);
        end
      end
      ST_GAP: begin
        // A sync FSM still active on the second gap cycle is forcibly cleared.
        if (!sync_state || gap_reg) begin
          fsm_rst_req = sync_state;
          if (frame_cnt_reg < frames_reg) begin
            state_next = ST_WAIT_SYNC;
            timer_next = '0;
          end else begin
            state_next = ST_DONE;
          end
        end else begin
          gap_next = 1'b1;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    if (abort && (state_reg != ST_IDLE)) begin
      state_next       = ST_IDLE;
      frame_cnt_next   = frame_cnt_reg;
      timeout_err_next = timeout_err_reg;
      sync_err_next    = sync_err_reg;
      fsm_rst_req      = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      len_reg         <= '0;
      frames_reg      <= '0;
      to_reg          <= '0;
      timer_reg       <= '0;
      bit_reg         <= '0;
      gap_reg         <= 1'b0;
      frame_cnt_reg   <= '0;
      timeout_err_reg <= 1'b0;
      sync_err_reg    <= 1'b0;
      sh_en_reg       <= 1'b0;
      busy_reg        <= 1'b0;
      frame_done_reg  <= 1'b0;
      done_reg        <= 1'b0;
    end else begin
      state_reg       <= state_next;
      len_reg         <= len_next;
      frames_reg      <= frames_next;
      to_reg          <= to_next;
      timer_reg       <= timer_next;
      bit_reg         <= bit_next;
      gap_reg         <= gap_next;
      frame_cnt_reg   <= frame_cnt_next;
      timeout_err_reg <= timeout_err_next;
      sync_err_reg    <= sync_err_next;
      sh_en_reg       <= (state_next == ST_SHIFT);
      busy_reg        <= (state_next != ST_IDLE);
      frame_done_reg  <= (state_reg == ST_SHIFT) && (state_next == ST_GAP);
      done_reg        <= (state_next == ST_DONE);
    end
  end

  sync_pulse_gen u_fsm_rst (
    .clk   (clk),
    .rst   (rst),
    .req   (fsm_rst_req),
    .pulse (fsm_rst)
  );

  assign sh_en       = sh_en_reg;
  assign busy        = busy_reg;
  assign frame_done  = frame_done_reg;
  assign done        = done_reg;
  assign frame_cnt   = frame_cnt_reg;
  assign timeout_err = timeout_err_reg;
  assign sync_err    = sync_err_reg;

endmodule

// File: doc/sync_shift_ctrl.md
SYNC_SHIFT_CTRL -- requirements
Module: sync_shift_ctrl

Interface
REQ-001 SHALL have parameter LEN_W, default 7, width of cfg_len and the bit counter (frames up to 64 bits).
REQ-002 SHALL have parameter FRM_W, default 8, width of cfg_frames and frame_cnt.
REQ-003 SHALL have parameter TO_W, default 16, width of cfg_timeout and the sync-wait timer.
REQ-004 SHALL have port clk, input, 1, single system clock; all state on rising edge.
REQ-005 SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-006 SHALL have port start, input, 1, request a capture run; honoured only in IDLE.
REQ-007 SHALL have port abort, input, 1, terminate any run.
REQ-008 SHALL have port sync_state, input, 1, state output of the sync FSM (1 = ACTIVE).
REQ-009 SHALL have port cfg_len, input, LEN_W, sh_en cycles per frame; 0 means 64.
REQ-010 SHALL have port cfg_frames, input, FRM_W, frames per run.
REQ-011 SHALL have port cfg_timeout, input, TO_W, max WAIT_SYNC cycles; 0 disables timeout.
REQ-012 SHALL have port sh_en, output, 1, shift enable to the sync FSM and shift register.
REQ-013 SHALL have port fsm_rst, output, 1, one-cycle clear pulse to the sync FSM.
REQ-014 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-015 SHALL have port frame_done, output, 1, one-cycle pulse per completed frame.
REQ-016 SHALL have port done, output, 1, one-cycle pulse at run completion.
REQ-017 SHALL have port frame_cnt, output, FRM_W, frames completed in the current run.
REQ-018 SHALL have port timeout_err, output, 1, sticky; sync not seen within cfg_timeout.
REQ-019 SHALL have port sync_err, output, 1, sticky; sync_state dropped during SHIFT.

Function
REQ-020 SHALL implement states IDLE, ARM, WAIT_SYNC, SHIFT, GAP, DONE; every output registered.
REQ-021 SHALL, on start in IDLE, latch cfg_len/cfg_frames/cfg_timeout, clear frame_cnt and both error flags, and enter ARM; later cfg changes are ignored until the next start.
REQ-022 SHALL assert fsm_rst for exactly the one ARM cycle, then enter WAIT_SYNC, or enter DONE directly if the latched cfg_frames is 0.
REQ-023 SHALL, in WAIT_SYNC, count cycles from 0; sync_state=1 moves to SHIFT, and sh_en rises on the next clock edge.
REQ-024 SHALL, when the timer equals a non-zero cfg_timeout before sync is seen, set timeout_err, pulse fsm_rst for one cycle, and return to IDLE with no done pulse; sync seen on the same cycle as the timeout wins.
REQ-025 SHALL hold sh_en high for exactly the latched cfg_len cycles (64 when cfg_len is 0), then deassert it and enter GAP.
REQ-026 SHALL increment frame_cnt and pulse frame_done in the first GAP cycle.
REQ-027 SHALL, if sync_state=0 during any SHIFT cycle, set sync_err, drop sh_en, pulse fsm_rst, and go to IDLE with frame_cnt unchanged.
REQ-028 SHALL wait in GAP until sync_state=0; if it is still 1 after 2 GAP cycles, pulse fsm_rst once and proceed.
REQ-029 SHALL leave GAP to WAIT_SYNC with the timer cleared when frame_cnt is below cfg_frames, otherwise to DONE.
REQ-030 SHALL pulse done for the one DONE cycle, then enter IDLE.
REQ-031 SHALL, on abort in any non-IDLE state, enter IDLE next cycle with sh_en=0 and a one-cycle fsm_rst pulse; abort has priority over start and every other transition; abort in IDLE is ignored.
REQ-032 SHALL saturate frame_cnt at its maximum and never wrap.

Reset
REQ-033 SHALL, on rst, asynchronously force IDLE with sh_en, fsm_rst, busy, frame_done, done, timeout_err, sync_err all 0 and frame_cnt 0.
REQ-034 SHALL, when rst asserts mid-SHIFT, drop sh_en immediately without a fsm_rst pulse, and resume operation on the first clock after rst deasserts.

Structure
REQ-035 SHALL place the state encoding (3-bit, localparam values) and the LEN_W/FRM_W/TO_W defaults in the shared sync-path package.
REQ-036 SHALL be a single module; the bit counter and timer are inline, and an optional sub-module is sync_pulse_gen for the one-cycle fsm_rst generator.

Verification
REQ-037 SHALL cover: cfg_len=8, cfg_frames=3, sync_state=1 four cycles after ARM -> three 8-cycle sh_en windows, frame_cnt steps 1,2,3, done once.
REQ-038 SHALL cover: cfg_timeout=10 with sync_state held 0 -> timeout_err=1 at the 10th WAIT_SYNC cycle, one fsm_rst pulse, busy=0, no done.
REQ-039 SHALL cover: sync_state dropped on the 3rd SHIFT cycle -> sync_err=1, sh_en=0 next cycle, frame_cnt=0.
REQ-040 SHALL cover: abort on the 5th SHIFT cycle of frame 2 -> IDLE next cycle, fsm_rst pulse, frame_cnt=1, no done.
REQ-041 SHALL cover: cfg_len=0 -> 64-cycle sh_en window; cfg_frames=0 -> ARM then done with sh_en never high.
REQ-042 SHALL cover: rst asserted mid-SHIFT -> all outputs 0 without waiting for a clock edge; start accepted immediately after release.
